// File: rtl/jednostka_skokow_pkg.sv
// Shared flow-control definitions: opcode values and default program address width.
package pkg_sterowanie;

    localparam int ADDR_W_DOMYSLNE = 8;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_JC   = 3'd2;
    localparam logic [2:0] OP_JNC  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;

endpackage

// File: rtl/jednostka_skokow_if.sv
// Bus between instruction decode / program counter and the jump unit.
interface jednostka_skokow_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 8
);
    localparam int SP_W = $clog2(DEPTH + 1);

    logic              instr_valid;
    logic [2:0]        op;
    logic [ADDR_W-1:0] cel;
    logic [ADDR_W-1:0] pc;
    logic              rlo;
    logic              jmp_en;
    logic [ADDR_W-1:0] adres_skoku;
    logic [SP_W-1:0]   sp;
    logic              stos_pelny;
    logic              stos_pusty;
    logic              blad_przepel;
    logic              blad_niedomiar;

    modport master (
        output instr_valid, op, cel, pc, rlo,
        input  jmp_en, adres_skoku, sp, stos_pelny, stos_pusty, blad_przepel, blad_niedomiar
    );

    modport slave (
        input  instr_valid, op, cel, pc, rlo,
        output jmp_en, adres_skoku, sp, stos_pelny, stos_pusty, blad_przepel, blad_niedomiar
    );
endinterface

// File: rtl/jednostka_skokow_stos_lifo.sv
// Return-address LIFO; register array updated on the falling edge, only sp is reset.
module stos_lifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 8,
    parameter int SP_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp_m1;

    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);
    assign sp_m1 = sp - 1'b1;
    // With sp == 0 this reads a stale entry; callers ignore top when empty.
    assign top   = mem[sp_m1[IDX_W-1:0]];

    always_ff @(negedge clk) begin
        if (push && !full)
            mem[sp[IDX_W-1:0]] <= din;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            sp <= '0;
        else if (push && !full)
            sp <= sp + 1'b1;
        else if (pop && !empty)
            sp <= sp - 1'b1;
    end
endmodule

// File: rtl/jednostka_skokow.sv
// Jump/call control unit: combinational flow-control decode feeding the program counter,
// return-address stack and sticky overflow/underflow flags.
module jednostka_skokow
    import pkg_sterowanie::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = ADDR_W_DOMYSLNE
) (
    input logic               clk,
    input logic               rst,
    jednostka_skokow_if.slave bus
);
    localparam int SP_W = $clog2(DEPTH + 1);

    logic              push, pop, pelny, pusty;
    logic              ustaw_przepel, ustaw_niedomiar;
    logic              blad_przepel_q, blad_niedomiar_q;
    logic [ADDR_W-1:0] szczyt, powrot;
    logic [SP_W-1:0]   sp;

    // Return address wraps naturally at 2^ADDR_W.
    assign powrot = bus.pc + ADDR_W'(1);

    stos_lifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SP_W(SP_W)) u_stos (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (powrot),
        .top   (szczyt),
        .sp    (sp),
        .full  (pelny),
        .empty (pusty)
    );

    always_comb begin
        bus.jmp_en      = 1'b0;
        bus.adres_skoku = '0;
        push            = 1'b0;
        pop             = 1'b0;
        ustaw_przepel   = 1'b0;
        ustaw_niedomiar = 1'b0;
        // Decode is held at NOP during reset so the counter sees no jump.
        if (!rst && bus.instr_valid) begin
            case (bus.op)
                OP_JMP: begin
                    bus.jmp_en      = 1'b1;
                    bus.adres_skoku = bus.cel;
                end
                OP_JC: begin
                    bus.jmp_en      = bus.rlo;
                    bus.adres_skoku = bus.cel;
                end
                OP_JNC: begin
                    bus.jmp_en      = !bus.rlo;
                    bus.adres_skoku = bus.cel;
                end
                OP_CALL: begin
                    if (pelny) begin
                        ustaw_przepel = 1'b1;
                    end else begin
                        bus.jmp_en      = 1'b1;
                        bus.adres_skoku = bus.cel;
                        push            = 1'b1;
                    end
                end
                OP_RET: begin
                    if (pusty) begin
                        ustaw_niedomiar = 1'b1;
                    end else begin
                        bus.jmp_en      = 1'b1;
                        bus.adres_skoku = szczyt;
                        pop             = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            blad_przepel_q   <= 1'b0;
            blad_niedomiar_q <= 1'b0;
        end else begin
            if (ustaw_przepel)   blad_przepel_q   <= 1'b1;
            if (ustaw_niedomiar) blad_niedomiar_q <= 1'b1;
        end
    end

    assign bus.sp             = sp;
    assign bus.stos_pelny     = pelny;
    assign bus.stos_pusty     = pusty;
    assign bus.blad_przepel   = blad_przepel_q;
    assign bus.blad_niedomiar = blad_niedomiar_q;
endmodule
